// File: rtl/ram_banked.sv
// Multi-port banked RAM with per-bank arbitration and a power-up clear of every row.
// Read latency 1 cycle (OUTREG=0) or 2 cycles (OUTREG=1); a port that loses arbitration sees ready=0 and must hold its request.
module ram_banked #(
  parameter int DATA   = 32,
  parameter int BYTE   = 8,
  parameter int DEPTH  = 16,
  parameter int BANK   = 2,
  parameter int PORT   = 2,
  parameter int OUTREG = 1,
  parameter int ARB    = 1,
  localparam int BYTESEL = DATA / BYTE,
  localparam int ADDR    = $clog2(DEPTH),
  localparam int BSEL    = (BANK > 1) ? $clog2(BANK) : 0
) (
  input  logic                             clk,
  input  logic                             reset_,
  input  logic [PORT-1:0]                  req,
  input  logic [PORT-1:0][BYTESEL-1:0]     en,
  input  logic [PORT-1:0]                  rw_,
  input  logic [PORT-1:0][ADDR-1:0]        addr,
  input  logic [PORT-1:0][DATA-1:0]        wdata,
  output logic [PORT-1:0]                  ready,
  output logic [PORT-1:0]                  rvalid,
  output logic [PORT-1:0][DATA-1:0]        rdata,
  output logic                             busy
);

  localparam int ROWS = DEPTH / BANK;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW   = (BSEL > 0) ? BSEL : 1;
  localparam int PW   = (PORT > 1) ? $clog2(PORT) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nxt;
  logic            run;
  logic [RW-1:0]   cnt;
  logic [BW-1:0]   bidx [PORT];
  logic [RW-1:0]   ridx [PORT];
  logic [PORT-1:0] gnt;
  logic [BANK-1:0] bgnt;
  logic [PW-1:0]   bport [BANK];
  logic [PW-1:0]   ptr [BANK];
  logic [DATA-1:0] mem [BANK][ROWS];
  logic [PORT-1:0] rv1;
  logic [DATA-1:0] d1 [PORT];

  always_ff @(posedge clk) begin
    if (!reset_) state <= INIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == RW'(ROWS - 1)) state_nxt = RUN;
  end

  always_comb begin
    run  = (state == RUN);
    busy = (state == INIT) || !reset_;
  end

  always_ff @(posedge clk) begin
    if (!reset_)           cnt <= '0;
    else if (state == INIT) cnt <= cnt + 1'b1;
  end

  // Low address bits pick the bank so consecutive words spread across banks.
  always_comb begin
    for (int p = 0; p < PORT; p++) begin
      bidx[p] = (BANK == 1) ? '0 : BW'(addr[p] & ADDR'(BANK - 1));
      ridx[p] = RW'(addr[p] >> BSEL);
    end
  end

  always_comb begin : arb
    logic [PW-1:0] p;
    p    = '0;
    gnt  = '0;
    bgnt = '0;
    for (int b = 0; b < BANK; b++) bport[b] = '0;
    for (int b = 0; b < BANK; b++) begin
      for (int k = 0; k < PORT; k++) begin
        p = (ARB == 1) ? PW'((int'(ptr[b]) + k) % PORT) : PW'(k);
        if (run && reset_ && !bgnt[b] && req[p] && bidx[p] == BW'(b)) begin
          gnt[p]   = 1'b1;
          bgnt[b]  = 1'b1;
          bport[b] = p;
        end
      end
    end
  end

  assign ready = gnt;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      for (int b = 0; b < BANK; b++) ptr[b] <= '0;
    end else begin
      for (int b = 0; b < BANK; b++)
        if (bgnt[b]) ptr[b] <= PW'((int'(bport[b]) + 1) % PORT);
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int b = 0; b < BANK; b++) mem[b][cnt] <= '0;
    end else begin
      for (int b = 0; b < BANK; b++)
        if (bgnt[b] && !rw_[bport[b]])
          for (int l = 0; l < BYTESEL; l++)
            if (en[bport[b]][l])
              mem[b][ridx[bport[b]]][l*BYTE +: BYTE] <= wdata[bport[b]][l*BYTE +: BYTE];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      rv1 <= '0;
      for (int p = 0; p < PORT; p++) d1[p] <= '0;
    end else begin
      rv1 <= gnt & rw_;
      for (int p = 0; p < PORT; p++)
        if (gnt[p] && rw_[p]) d1[p] <= mem[bidx[p]][ridx[p]];
    end
  end

  generate
    if (OUTREG != 0) begin : g_oreg
      logic [PORT-1:0] rv2;
      logic [DATA-1:0] d2 [PORT];
      always_ff @(posedge clk) begin
        if (!reset_) begin
          rv2 <= '0;
          for (int p = 0; p < PORT; p++) d2[p] <= '0;
        end else begin
          rv2 <= rv1;
          for (int p = 0; p < PORT; p++)
            if (rv1[p]) d2[p] <= d1[p];
        end
      end
      assign rvalid = rv2;
      always_comb for (int p = 0; p < PORT; p++) rdata[p] = d2[p];
    end else begin : g_noreg
      assign rvalid = rv1;
      always_comb for (int p = 0; p < PORT; p++) rdata[p] = d1[p];
    end
  endgenerate

endmodule
